// File: rtl/pe_stream_sequencer_if.sv
// Bundled start/status, SRAM read port, PE stream and psum return of pe_stream_sequencer.
// The abort input exists only when PE_SEQ_ABORT_EN is defined.
interface pe_stream_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 14,
  parameter int IDX_W  = 2
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [26:0]       mem_rdata;
  logic [26:0]       data_out;
  logic              data_valid;
  logic [WIDTH-1:0]  psum_in;
  logic [WIDTH-1:0]  psum_out;
  logic              psum_valid;
  logic [IDX_W-1:0]  psum_idx;

`ifdef PE_SEQ_ABORT_EN
  logic              abort;

  modport master (
    input  start, abort, mem_rdata, psum_in,
    output busy, done, mem_ren, mem_addr, data_out, data_valid,
           psum_out, psum_valid, psum_idx
  );

  modport slave (
    output start, abort, mem_rdata, psum_in,
    input  busy, done, mem_ren, mem_addr, data_out, data_valid,
           psum_out, psum_valid, psum_idx
  );
`else
  modport master (
    input  start, mem_rdata, psum_in,
    output busy, done, mem_ren, mem_addr, data_out, data_valid,
           psum_out, psum_valid, psum_idx
  );

  modport slave (
    output start, mem_rdata, psum_in,
    input  busy, done, mem_ren, mem_addr, data_out, data_valid,
           psum_out, psum_valid, psum_idx
  );
`endif
endinterface

// File: rtl/pe_stream_sequencer.sv
// Host-side sequencer: streams SRAM words to the PE array, then captures the returned psums.
// Define PE_SEQ_ABORT_EN to add the abort input that cancels a run from any busy state.
module pe_stream_sequencer #(
  parameter int K          = 1,
  parameter int ROW_LENGTH = 7,
  parameter int O_CH       = 3,
  parameter int WIDTH      = 14,
  parameter int PSUM_WAIT  = 3,
  parameter int ADDR_W     = 8,
  parameter int IDX_W      = (O_CH > 1) ? $clog2(O_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  pe_stream_sequencer_if.master bus
);
  localparam int TOTAL = (O_CH + 1) * ROW_LENGTH * K;
  localparam int CNT_W = $clog2(PSUM_WAIT + O_CH + 1) + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(PSUM_WAIT);
  localparam logic [CNT_W-1:0]  ROW_LAST  = CNT_W'(O_CH - 1);
  localparam logic [CNT_W-1:0]  ROW_END   = CNT_W'(O_CH);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, COLLECT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_ren_q, mem_ren_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  psum_out_q, psum_out_d;
  logic [IDX_W-1:0]  psum_idx_q, psum_idx_d;
  logic              psum_valid_q, psum_valid_d;
  logic              done_q, done_d;
  logic              rd_pend_q;
  logic              data_valid_q;
  logic [26:0]       data_out_q;
  logic              abort_hit;

`ifdef PE_SEQ_ABORT_EN
  assign abort_hit = bus.abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start)                state_d = FEED;
      FEED:    if (mem_addr_q == LAST_ADDR)  state_d = DRAIN;
      DRAIN:   if (cnt_q == WAIT_LAST)       state_d = COLLECT;
      COLLECT: if (cnt_q == ROW_END)         state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  // DRAIN spans PSUM_WAIT+1 cycles: two cover the SRAM/output pipeline, the rest the array latency.
  // COLLECT spans O_CH sampling cycles plus the done cycle, so busy covers done.
  always_comb begin
    mem_ren_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    cnt_d        = cnt_q;
    psum_out_d   = psum_out_q;
    psum_idx_d   = psum_idx_q;
    psum_valid_d = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mem_ren_d  = 1'b1;
          mem_addr_d = '0;
        end
      end
      FEED: begin
        cnt_d = '0;
        if (mem_addr_q != LAST_ADDR) begin
          mem_ren_d  = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        cnt_d = (cnt_q == WAIT_LAST) ? '0 : cnt_q + 1'b1;
      end
      COLLECT: begin
        if (cnt_q != ROW_END) begin
          psum_out_d   = bus.psum_in;
          psum_idx_d   = IDX_W'(cnt_q);
          psum_valid_d = 1'b1;
          done_d       = (cnt_q == ROW_LAST);
          cnt_d        = cnt_q + 1'b1;
        end else begin
          cnt_d      = '0;
          mem_addr_d = '0;
        end
      end
      default: ;
    endcase
    if (abort_hit) begin
      mem_ren_d    = 1'b0;
      mem_addr_d   = '0;
      cnt_d        = '0;
      psum_valid_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_ren_q    <= 1'b0;
      mem_addr_q   <= '0;
      cnt_q        <= '0;
      psum_out_q   <= '0;
      psum_idx_q   <= '0;
      psum_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      mem_ren_q    <= mem_ren_d;
      mem_addr_q   <= mem_addr_d;
      cnt_q        <= cnt_d;
      psum_out_q   <= psum_out_d;
      psum_idx_q   <= psum_idx_d;
      psum_valid_q <= psum_valid_d;
      done_q       <= done_d;
    end
  end

  // rd_pend marks the cycle in which mem_rdata answers last cycle's read.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_pend_q    <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      rd_pend_q    <= mem_ren_q && !abort_hit;
      data_valid_q <= rd_pend_q && !abort_hit;
      data_out_q   <= (rd_pend_q && !abort_hit) ? bus.mem_rdata : '0;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.psum_out   = psum_out_q;
  assign bus.psum_valid = psum_valid_q;
  assign bus.psum_idx   = psum_idx_q;
endmodule

// File: tb/tb_pe_stream_sequencer.sv
// Bench for pe_stream_sequencer: SRAM model (word i = i), PE-array psum model, scoreboard queues.
// Define PE_SEQ_ABORT_EN for both RTL and bench to cover the abort scenario.
module tb_pe_stream_sequencer;
  localparam int K          = 1;
  localparam int ROW_LENGTH = 7;
  localparam int O_CH       = 3;
  localparam int WIDTH      = 14;
  localparam int PSUM_WAIT  = 3;
  localparam int ADDR_W     = 8;
  localparam int IDX_W      = 2;
  localparam int TOTAL      = (O_CH + 1) * ROW_LENGTH * K;
  localparam int DONE_REL   = TOTAL + PSUM_WAIT + O_CH + 2;
  localparam int RUN_LEN    = DONE_REL + 1;
  localparam logic [WIDTH-1:0] PSUM_JUNK  = 14'h1234;
  localparam logic [26:0]      RDATA_JUNK = 27'h5A5A5A5;

  typedef struct { logic [26:0] val; int cyc; } word_exp_t;
  typedef struct { logic [WIDTH-1:0] val; int idx; int cyc; } psum_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   n_ren = 0, n_dv = 0, n_pv = 0, n_done = 0;
  word_exp_t q_addr[$];
  word_exp_t q_data[$];
  psum_exp_t q_psum[$];
  logic [WIDTH-1:0] pv [O_CH];
  logic dv_prev = 1'b0;
  int   arr_k = 0;

  always #5 clk = ~clk;

  pe_stream_sequencer_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  pe_stream_sequencer #(
    .K(K), .ROW_LENGTH(ROW_LENGTH), .O_CH(O_CH), .WIDTH(WIDTH),
    .PSUM_WAIT(PSUM_WAIT), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  // One-cycle-latency SRAM holding word i = i.
  always @(posedge clk) bus.mem_rdata <= bus.mem_ren ? 27'(bus.mem_addr) : RDATA_JUNK;

  task automatic push_run(input int base);
    for (int k = 0; k < TOTAL; k++) begin
      q_addr.push_back('{val: 27'(k), cyc: base + k + 1});
      q_data.push_back('{val: 27'(k), cyc: base + k + 3});
    end
  endtask

  // Advance one clock; observe outputs mid-cycle, score them, then drive the array model.
  task automatic step();
    word_exp_t e;
    psum_exp_t p;
    int r;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.mem_ren === 1'b1) begin
      n_ren++;
      n_cmp++;
      if (q_addr.size() == 0) begin
        n_err++;
        $display("FAIL mem_read_unexpected: addr=%0d at cycle %0d, no read expected", bus.mem_addr, cyc);
      end else begin
        e = q_addr.pop_front();
        if (27'(bus.mem_addr) !== e.val || cyc != e.cyc) begin
          n_err++;
          $display("FAIL mem_addr: got addr=%0d cycle=%0d, want addr=%0d cycle=%0d", bus.mem_addr, cyc, e.val, e.cyc);
        end
      end
    end
    n_cmp++;
    if (bus.data_valid === 1'b1) begin
      n_dv++;
      if (q_data.size() == 0) begin
        n_err++;
        $display("FAIL data_unexpected: data_out=%0d at cycle %0d, no word expected", bus.data_out, cyc);
      end else begin
        e = q_data.pop_front();
        if (bus.data_out !== e.val || cyc != e.cyc) begin
          n_err++;
          $display("FAIL data_out: got %0d cycle=%0d, want %0d cycle=%0d", bus.data_out, cyc, e.val, e.cyc);
        end
      end
    end else if (bus.data_out !== 27'd0 || bus.data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL data_idle: got data_out=%0d valid=%b, want 0/0 at cycle %0d", bus.data_out, bus.data_valid, cyc);
    end
    n_cmp++;
    if (bus.psum_valid === 1'b1) begin
      n_pv++;
      if (bus.done === 1'b1) n_done++;
      if (q_psum.size() == 0) begin
        n_err++;
        $display("FAIL psum_unexpected: psum_out=%h idx=%0d at cycle %0d", bus.psum_out, bus.psum_idx, cyc);
      end else begin
        p = q_psum.pop_front();
        if (bus.psum_out !== p.val || bus.psum_idx !== IDX_W'(p.idx) || cyc != p.cyc ||
            bus.done !== (p.idx == O_CH - 1)) begin
          n_err++;
          $display("FAIL psum: got val=%h idx=%0d cycle=%0d done=%b, want val=%h idx=%0d cycle=%0d done=%b",
                   bus.psum_out, bus.psum_idx, cyc, bus.done, p.val, p.idx, p.cyc, (p.idx == O_CH - 1));
        end
      end
    end else if (bus.done !== 1'b0) begin
      n_done++;
      n_err++;
      $display("FAIL done_alone: got done=%b without psum_valid at cycle %0d, want 0", bus.done, cyc);
    end
    // PE-array model: row r psum is presented PSUM_WAIT+r cycles after the last stream word.
    if (dv_prev && bus.data_valid !== 1'b1) arr_k = 1;
    else if (arr_k != 0) arr_k++;
    dv_prev = (bus.data_valid === 1'b1);
    if (arr_k >= PSUM_WAIT && arr_k < PSUM_WAIT + O_CH) begin
      r = arr_k - PSUM_WAIT;
      bus.psum_in = pv[r];
      q_psum.push_back('{val: pv[r], idx: r, cyc: cyc + 1});
    end else begin
      bus.psum_in = PSUM_JUNK;
      if (arr_k >= PSUM_WAIT + O_CH) arr_k = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.psum_in = PSUM_JUNK;
`ifdef PE_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    #12;
    n_cmp++;
    if ({bus.busy, bus.done, bus.mem_ren, bus.data_valid, bus.psum_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got busy/done/ren/dv/pv=%b, want 00000",
               {bus.busy, bus.done, bus.mem_ren, bus.data_valid, bus.psum_valid});
    end
    n_cmp++;
    if (bus.mem_addr !== '0 || bus.data_out !== '0 || bus.psum_out !== '0 || bus.psum_idx !== '0) begin
      n_err++;
      $display("FAIL reset_buses: got addr=%0d data=%0d psum=%h idx=%0d, want all 0",
               bus.mem_addr, bus.data_out, bus.psum_out, bus.psum_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    n_cmp++;
    if (bus.busy !== 1'b0 || n_ren != 0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b reads=%0d, want 0/0", bus.busy, n_ren);
    end
  endtask

  task automatic test_single_run(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c, input int poke_rel);
    int base, ren0, dv0, pv0, d0;
    ren0 = n_ren; dv0 = n_dv; pv0 = n_pv; d0 = n_done;
    pv[0] = a; pv[1] = b; pv[2] = c;
    base = cyc;
    push_run(base);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_busy_rise: got busy=%b, want 1", tag, bus.busy);
    end
    while (cyc < base + DONE_REL) begin
      if (poke_rel != 0 && cyc == base + poke_rel) begin
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
      end else begin
        step();
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_cycle: got busy=%b done=%b, want 1/1", tag, bus.busy, bus.done);
    end
    step();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_busy_fall: got busy=%b done=%b, want 0/0", tag, bus.busy, bus.done);
    end
    repeat (3) step();
    n_cmp++;
    if (n_ren - ren0 != TOTAL || n_dv - dv0 != TOTAL || n_pv - pv0 != O_CH || n_done - d0 != 1) begin
      n_err++;
      $display("FAIL %s_counts: got reads=%0d words=%0d psums=%0d dones=%0d, want %0d/%0d/%0d/1",
               tag, n_ren - ren0, n_dv - dv0, n_pv - pv0, n_done - d0, TOTAL, TOTAL, O_CH);
    end
    n_cmp++;
    if (q_addr.size() != 0 || q_data.size() != 0 || q_psum.size() != 0) begin
      n_err++;
      $display("FAIL %s_leftover: got pending addr/data/psum=%0d/%0d/%0d, want 0/0/0",
               tag, q_addr.size(), q_data.size(), q_psum.size());
    end
  endtask

  task automatic test_start_ignored();
    test_single_run("ignored", 14'h2000, 14'h0001, 14'h1FFF, 11);
  endtask

  task automatic test_back_to_back();
    int base, dv0, pv0, d0;
    dv0 = n_dv; pv0 = n_pv; d0 = n_done;
    pv[0] = 14'h0A5; pv[1] = 14'h15A; pv[2] = 14'h3FF;
    base = cyc;
    push_run(base);
    push_run(base + RUN_LEN);
    bus.start = 1'b1;
    while (cyc < base + RUN_LEN) step();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.mem_addr !== '0 || n_done - d0 != 1) begin
      n_err++;
      $display("FAIL b2b_gap: got busy=%b addr=%0d dones=%0d, want 0/0/1", bus.busy, bus.mem_addr, n_done - d0);
    end
    step();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.mem_ren !== 1'b1 || bus.mem_addr !== '0) begin
      n_err++;
      $display("FAIL b2b_restart: got busy=%b ren=%b addr=%0d, want 1/1/0", bus.busy, bus.mem_ren, bus.mem_addr);
    end
    while (cyc < base + 2 * RUN_LEN + 3) step();
    n_cmp++;
    if (n_dv - dv0 != 2 * TOTAL || n_pv - pv0 != 2 * O_CH || n_done - d0 != 2 ||
        q_data.size() != 0 || q_psum.size() != 0) begin
      n_err++;
      $display("FAIL b2b_counts: got words=%0d psums=%0d dones=%0d, want %0d/%0d/2",
               n_dv - dv0, n_pv - pv0, n_done - d0, 2 * TOTAL, 2 * O_CH);
    end
  endtask

  task automatic test_reset_mid();
    int base, dv0, pv0, d0;
    pv[0] = 14'h0A5; pv[1] = 14'h15A; pv[2] = 14'h3FF;
    base = cyc;
    push_run(base);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (cyc < base + 16) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.mem_ren, bus.data_valid, bus.psum_valid} !== 5'b0 ||
        bus.mem_addr !== '0 || bus.data_out !== '0 || bus.psum_out !== '0 || bus.psum_idx !== '0) begin
      n_err++;
      $display("FAIL midreset_async: got busy=%b ren=%b addr=%0d dv=%b data=%0d pv=%b psum=%h, want all 0",
               bus.busy, bus.mem_ren, bus.mem_addr, bus.data_valid, bus.data_out, bus.psum_valid, bus.psum_out);
    end
    q_addr.delete();
    q_data.delete();
    q_psum.delete();
    dv_prev = 1'b0;
    arr_k = 0;
    step();
    rst_n = 1'b1;
    dv0 = n_dv; pv0 = n_pv; d0 = n_done;
    repeat (45) step();
    n_cmp++;
    if (n_dv != dv0 || n_pv != pv0 || n_done != d0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_quiet: got words=%0d psums=%0d dones=%0d busy=%b, want 0/0/0/0",
               n_dv - dv0, n_pv - pv0, n_done - d0, bus.busy);
    end
    test_single_run("after_reset", 14'h3FFF, 14'h0000, 14'h2AAA, 0);
  endtask

`ifdef PE_SEQ_ABORT_EN
  task automatic test_abort();
    int base, pv0, d0;
    pv[0] = 14'h0A5; pv[1] = 14'h15A; pv[2] = 14'h3FF;
    base = cyc;
    push_run(base);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (cyc < base + TOTAL + 3) step();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.mem_ren !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drain_state: got busy=%b ren=%b, want 1/0", bus.busy, bus.mem_ren);
    end
    pv0 = n_pv; d0 = n_done;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    q_psum.delete();
    arr_k = 0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.psum_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b pv=%b done=%b, want 0/0/0", bus.busy, bus.psum_valid, bus.done);
    end
    repeat (10) step();
    n_cmp++;
    if (n_pv != pv0 || n_done != d0) begin
      n_err++;
      $display("FAIL abort_quiet: got psums=%0d dones=%0d, want 0/0", n_pv - pv0, n_done - d0);
    end
    test_single_run("after_abort", 14'h0A5, 14'h15A, 14'h3FF, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_single_run("run1", 14'h0A5, 14'h15A, 14'h3FF, 0);
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef PE_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_stream_sequencer.md
Name: pe_stream_sequencer

Overview:
- Host-side driver for the PE array's serial stream interface, built as the counterpart to the PE array's consumer side.
- On `start`, reads `(O_CH+1)*ROW_LENGTH*K` 27-bit words from a 1-cycle-latency SRAM and emits them back-to-back on `data_out`. Each column carries O_CH weight words followed by 1 activation word.
- After a fixed drain gap it captures the O_CH serial psums returned by the array and presents them indexed, with a valid strobe.

Parameters:
- K, 1, number of runs (column groups multiplier).
- ROW_LENGTH, 7, PE row length (columns per run).
- O_CH, 3, number of PE rows = number of psums returned.
- WIDTH, 14, psum bit width.
- PSUM_WAIT, 3, cycles from last data word to first valid psum on `psum_in` (≥1).
- ADDR_W, 8, SRAM address width; must hold TOTAL-1, where TOTAL=(O_CH+1)*ROW_LENGTH*K.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high from first FEED cycle through the done cycle.
- done  out  1  single-cycle pulse with the last `psum_valid`.
- mem_ren  out  1  SRAM read enable.
- mem_addr  out  ADDR_W  SRAM word address.
- mem_rdata  in  27  SRAM data; valid the cycle after `mem_ren`.
- data_out  out  27  stream word to the PE array.
- data_valid  out  1  `data_out` holds a stream word.
- psum_in  in  WIDTH  serial psum from the PE array.
- psum_out  out  WIDTH  captured psum.
- psum_valid  out  1  `psum_out` valid.
- psum_idx  out  clog2(O_CH) (min 1)  row index of `psum_out`.

Behaviour:
- Reset (async, `rst_in`=0): state IDLE; all outputs 0; all counters 0.
- Registered outputs: every output is registered except `busy`, which decodes state.
- FSM states: IDLE, FEED, DRAIN, COLLECT.
- IDLE: `start`=1 at edge E0 → FEED; at E0 `mem_ren`<=1, `mem_addr`<=0.
- FEED:
  - `mem_addr` increments each cycle 0..TOTAL-1 in linear order: word j*(O_CH+1)+r, with r<O_CH weight row r and r=O_CH the activation.
  - `mem_ren`=1 for exactly TOTAL cycles, then 0; state → DRAIN on the edge after `mem_addr`=TOTAL-1.
- Data path:
  - `data_out`<=`mem_rdata` and `data_valid`<=1 on the edge after the SRAM returns data. Word 0 is valid in the 3rd cycle after E0.
  - Words are contiguous, one per cycle, no gaps.
  - `data_out` returns to 0 with `data_valid`=0 the cycle after the last word.
- DRAIN: let L be the cycle `data_out` holds word TOTAL-1. `psum_in` for row 0 is sampled at the end of cycle L+PSUM_WAIT, row r at the end of L+PSUM_WAIT+r. State → COLLECT for those O_CH sampling cycles.
- COLLECT:
  - Each sample registers `psum_out`<=`psum_in`, `psum_idx`<=r and `psum_valid`<=1, so it is visible the following cycle.
  - `psum_valid` is high for exactly O_CH consecutive cycles with `psum_idx` 0..O_CH-1.
  - `psum_out` and `psum_idx` hold their last values after `psum_valid` falls.
- done: high in the same cycle as the `psum_valid` with `psum_idx`=O_CH-1. The FSM is in IDLE the next cycle and `busy` drops.
- Start handling: `start` while busy is ignored (not queued). `start` held high re-triggers from IDLE the cycle after done, so back-to-back runs are legal.
- Counters: sized for TOTAL and PSUM_WAIT+O_CH; no wrap beyond TOTAL-1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No partial done or `psum_valid` follows.
- PSUM_WAIT=1 (minimum): DRAIN lasts 0 extra cycles and sampling begins the cycle after L.

Optional Feature:
- Macro: PE_SEQ_ABORT_EN.
- Defined:
  - Adds input `abort` (1 bit). `abort`=1 in any non-IDLE state → IDLE on the next edge.
  - `mem_ren`, `data_valid` and `psum_valid` are forced 0 on that edge; no done is generated.
  - `abort` in IDLE has no effect. `abort` and `start` together in IDLE → start wins.
- Undefined: no `abort` port; runs always complete.

Test Plan:
- Defaults, SRAM word i = i, `start` pulse at E0:
  - `mem_addr` 0..27 over 28 cycles.
  - `data_out` = 0,1,...,27 contiguous from the 3rd cycle after E0, with `data_valid` high for exactly 28 cycles.
- Same run, array model drives `psum_in`=14'h0A5, 14'h15A, 14'h3FF on cycles L+3, L+4, L+5:
  - `psum_out` shows those values on L+4..L+6 with `psum_idx` 0,1,2.
  - done at L+6; `busy` low at L+7.
- `start` pulsed again mid-FEED (`mem_addr`=10): ignored; sequence and timing identical to test 1.
- `start` held high for two runs: second run's `mem_addr`=0 appears the cycle after first done; 2 done pulses total.
- `rst_in` low at `mem_addr`=15: all outputs 0 asynchronously. After release, no `data_valid`, `psum_valid` or done until the next `start`.
- PE_SEQ_ABORT_EN, `abort` during DRAIN: IDLE next cycle, zero `psum_valid` pulses, no done; a following `start` runs normally.
